// File: rtl/m_gen_pkg.sv
// Shared types and helpers for the M-generation coordinate sweep.
// State encoding, symbol width helper and default F width.
package m_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    COLLECT,
    DONE
  } state_t;

  localparam int FW_DEF = 64;

  function automatic int sym_width(input int a);
    return $clog2(a) + 1;
  endfunction

endpackage

// File: rtl/m_gen_argmin.sv
// Streaming (value,index) minimum tracker.
// Strict less-than keeps the earliest index on ties.
module m_gen_argmin
  import m_gen_pkg::*;
#(
  parameter int FW = FW_DEF,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [FW-1:0] in_val,
  input  logic [IW-1:0] in_idx,
  output logic [FW-1:0] min_val,
  output logic [IW-1:0] min_idx
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_val <= '1;
      min_idx <= '0;
    end else if (clear) begin
      min_val <= '1;
      min_idx <= '0;
    end else if (in_valid && (in_val < min_val)) begin
      min_val <= in_val;
      min_idx <= in_idx;
    end
  end

endmodule

// File: rtl/m_gen_sweep.sv
// Coordinate-descent search engine: emits candidate rows per coordinate,
// commits the argmin symbol and repeats passes until stable or capped.
module m_gen_sweep
  import m_gen_pkg::*;
#(
  parameter int J        = 14,
  parameter int A        = 2,
  parameter int FW       = FW_DEF,
  parameter int MAX_PASS = 4,
  localparam int AWIDTH  = sym_width(A)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [J*AWIDTH-1:0] x_init,
  input  logic              x_init_tvalid,
  output logic              x_init_tready,
  output logic [J*AWIDTH-1:0] cand,
  output logic              cand_tvalid,
  input  logic              cand_tready,
  output logic              cand_tlast,
  input  logic [FW-1:0]     f_value,
  input  logic              f_value_tvalid,
  output logic [J*AWIDTH-1:0] best_x,
  output logic [FW-1:0]     best_f,
  output logic              best_tvalid,
  output logic              busy
);

  localparam int JW = (J > 1) ? $clog2(J) : 1;
  localparam int PW = $clog2(MAX_PASS) + 1;
  localparam int XW = J * AWIDTH;

  state_t state, state_nx;

  logic [JW-1:0]     j;
  logic [AWIDTH-1:0] sym;
  logic [AWIDTH-1:0] res_cnt;
  logic [PW-1:0]     pass;
  logic              changed;
  logic [XW-1:0]     cur_x;
  logic [XW-1:0]     row;
  logic [XW-1:0]     nxt_x;
  logic [AWIDTH-1:0] old_sym;
  logic [AWIDTH-1:0] amin_idx;
  logic [FW-1:0]     amin_val;

  logic start, hs, sym_last, take, dec;
  logic last_j, chg, stop;

  always_comb begin
    row = cur_x;
    row[int'(j)*AWIDTH +: AWIDTH] = sym;
    nxt_x = cur_x;
    nxt_x[int'(j)*AWIDTH +: AWIDTH] = amin_idx;
    old_sym = cur_x[int'(j)*AWIDTH +: AWIDTH];
  end

  assign start    = (state == IDLE) && x_init_tvalid;
  assign hs       = (state == EMIT) && cand_tready;
  assign sym_last = (sym == AWIDTH'(A - 1));
  assign take     = f_value_tvalid
                 && ((state == EMIT) || (state == COLLECT))
                 && (res_cnt < AWIDTH'(A));
  assign dec      = (state == COLLECT) && (res_cnt == AWIDTH'(A));
  assign last_j   = (j == JW'(J - 1));
  assign chg      = (amin_idx != old_sym);
  assign stop     = !(changed || chg)
                 || ((int'(pass) + 1) == MAX_PASS);

  m_gen_argmin #(
    .FW (FW),
    .IW (AWIDTH)
  ) u_argmin (
    .clk      (clk),
    .rst      (rst),
    .clear    (start || dec),
    .in_valid (take),
    .in_val   (f_value),
    .in_idx   (res_cnt),
    .min_val  (amin_val),
    .min_idx  (amin_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    x_init_tready = 1'b0;
    busy          = 1'b1;
    cand_tvalid   = 1'b0;
    cand_tlast    = 1'b0;
    cand          = '0;
    best_tvalid   = 1'b0;
    unique case (state)
      IDLE: begin
        x_init_tready = 1'b1;
        busy          = 1'b0;
        if (x_init_tvalid) state_nx = EMIT;
      end
      EMIT: begin
        cand_tvalid = 1'b1;
        cand_tlast  = sym_last;
        cand        = row;
        if (hs && sym_last) state_nx = COLLECT;
      end
      COLLECT: begin
        if (dec) begin
          if (!last_j)   state_nx = EMIT;
          else if (stop) state_nx = DONE;
          else           state_nx = EMIT;
        end
      end
      DONE: begin
        best_tvalid = 1'b1;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_x   <= '0;
      j       <= '0;
      sym     <= '0;
      pass    <= '0;
      changed <= 1'b0;
      res_cnt <= '0;
      best_x  <= '0;
      best_f  <= '0;
    end else begin
      if (take) res_cnt <= res_cnt + AWIDTH'(1);
      unique case (state)
        IDLE: begin
          if (x_init_tvalid) begin
            cur_x   <= x_init;
            j       <= '0;
            sym     <= '0;
            pass    <= '0;
            changed <= 1'b0;
            res_cnt <= '0;
            best_f  <= '1;
          end
        end
        EMIT: begin
          if (hs) sym <= sym_last ? '0 : sym + AWIDTH'(1);
        end
        COLLECT: begin
          if (dec) begin
            cur_x   <= nxt_x;
            best_f  <= amin_val;
            res_cnt <= '0;
            sym     <= '0;
            if (!last_j) begin
              j       <= j + JW'(1);
              changed <= changed || chg;
            end else begin
              pass    <= pass + PW'(1);
              j       <= '0;
              changed <= 1'b0;
              // best_x lands together with the completion pulse
              if (stop) best_x <= nxt_x;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m_gen_sweep.sv
// Bench for m_gen_sweep: J=4, A=2, MAX_PASS=4 against a
// latency-3 evaluator model (Hamming / tie / per-pass flip).
module tb_m_gen_sweep;

  localparam int J  = 4;
  localparam int A  = 2;
  localparam int AW = 2;
  localparam int XW = J * AW;
  localparam int FW = 64;

  localparam int M_HAM  = 0;
  localparam int M_TIE  = 1;
  localparam int M_FLIP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [XW-1:0] x_init = '0;
  logic          x_init_tvalid = 1'b0;
  logic          x_init_tready;
  logic [XW-1:0] cand;
  logic          cand_tvalid;
  logic          cand_tready = 1'b0;
  logic          cand_tlast;
  logic [FW-1:0] f_value = '0;
  logic          f_value_tvalid = 1'b0;
  logic [XW-1:0] best_x;
  logic [FW-1:0] best_f;
  logic          best_tvalid;
  logic          busy;

  m_gen_sweep #(
    .J        (J),
    .A        (A),
    .FW       (FW),
    .MAX_PASS (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .x_init         (x_init),
    .x_init_tvalid  (x_init_tvalid),
    .x_init_tready  (x_init_tready),
    .cand           (cand),
    .cand_tvalid    (cand_tvalid),
    .cand_tready    (cand_tready),
    .cand_tlast     (cand_tlast),
    .f_value        (f_value),
    .f_value_tvalid (f_value_tvalid),
    .best_x         (best_x),
    .best_f         (best_f),
    .best_tvalid    (best_tvalid),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  int            mode = M_HAM;
  logic [XW-1:0] tgt = '0;
  bit            bp = 1'b0;
  int            cand_cnt = 0;

  function automatic logic [63:0] model_f(input logic [XW-1:0] c,
                                          input int idx);
    logic [63:0] f;
    logic [AW-1:0] pref;
    f = 0;
    pref = (((idx / (A * J)) % 2) == 0) ? AW'(1) : AW'(0);
    for (int k = 0; k < J; k++) begin
      if (mode == M_HAM && c[k*AW +: AW] != tgt[k*AW +: AW]) f++;
      if (mode == M_FLIP && c[k*AW +: AW] != pref) f++;
    end
    if (mode == M_TIE) f = 5;
    return f;
  endfunction

  bit            pv [3];
  logic [63:0]   pf [3];
  bit            stalled = 1'b0;
  logic [XW-1:0] held = '0;

  // evaluator model: accepts on the coming edge, answers 3 cycles later
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        pv[k] = 1'b0;
        pf[k] = '0;
      end
      f_value_tvalid = 1'b0;
      cand_tready = 1'b0;
      stalled = 1'b0;
    end else begin
      f_value_tvalid = pv[2];
      f_value = pf[2];
      pv[2] = pv[1]; pf[2] = pf[1];
      pv[1] = pv[0]; pf[1] = pf[0];
      pv[0] = 1'b0;
      cand_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cand_tvalid && stalled)
        chk("stall_stable", 64'(cand), 64'(held));
      if (cand_tvalid && cand_tready) begin
        chk("tlast", 64'(cand_tlast), 64'((cand_cnt % 2) == 1));
        pv[0] = 1'b1;
        pf[0] = model_f(cand, cand_cnt);
        cand_cnt++;
        stalled = 1'b0;
      end else begin
        stalled = cand_tvalid;
        held = cand;
      end
    end
  end

  typedef struct {
    int            mode;
    logic [XW-1:0] xi;
    logic [XW-1:0] tgt;
    bit            bp;
    logic [XW-1:0] ex;
    logic [63:0]   ef;
    int            ec;
  } vec_t;

  vec_t tbl [7];

  task automatic run_vec(input vec_t v, input int id);
    bit seen;
    seen = 1'b0;
    mode = v.mode;
    tgt = v.tgt;
    bp = v.bp;
    cand_cnt = 0;
    @(negedge clk);
    x_init = v.xi;
    x_init_tvalid = 1'b1;
    @(posedge clk);
    #1;
    x_init_tvalid = 1'b0;
    chk($sformatf("v%0d_busy", id), 64'(busy), 64'd1);
    chk($sformatf("v%0d_tready_lo", id), 64'(x_init_tready), 64'd0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #2;
      if (best_tvalid) begin
        seen = 1'b1;
        break;
      end
    end
    chk($sformatf("v%0d_done", id), 64'(seen), 64'd1);
    chk($sformatf("v%0d_best_x", id), 64'(best_x), 64'(v.ex));
    chk($sformatf("v%0d_best_f", id), best_f, v.ef);
    chk($sformatf("v%0d_cands", id), 64'(cand_cnt), 64'(v.ec));
    @(negedge clk);
    #2;
    chk($sformatf("v%0d_pulse", id), 64'(best_tvalid), 64'd0);
    chk($sformatf("v%0d_idle", id), 64'(busy), 64'd0);
    chk($sformatf("v%0d_hold_x", id), 64'(best_x), 64'(v.ex));
    chk($sformatf("v%0d_ready", id), 64'(x_init_tready), 64'd1);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_tready"}, 64'(x_init_tready), 64'd1);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_cvalid"}, 64'(cand_tvalid), 64'd0);
    chk({nm, "_cand"}, 64'(cand), 64'd0);
    chk({nm, "_bvalid"}, 64'(best_tvalid), 64'd0);
    chk({nm, "_bx"}, 64'(best_x), 64'd0);
    chk({nm, "_bf"}, best_f, 64'd0);
  endtask

  initial begin
    vec_t v;
    bit hit;
    // {mode, x_init, target, backpressure, best_x, best_f, candidates}
    tbl[0] = '{M_HAM,  8'h00, 8'h44, 1'b0, 8'h44, 64'd0, 16};
    tbl[1] = '{M_HAM,  8'h00, 8'h44, 1'b1, 8'h44, 64'd0, 16};
    tbl[2] = '{M_TIE,  8'h00, 8'h00, 1'b0, 8'h00, 64'd5, 8};
    tbl[3] = '{M_TIE,  8'h55, 8'h00, 1'b0, 8'h00, 64'd5, 16};
    tbl[4] = '{M_FLIP, 8'h00, 8'h00, 1'b0, 8'h00, 64'd0, 32};
    tbl[5] = '{M_HAM,  8'h55, 8'h00, 1'b1, 8'h00, 64'd0, 16};
    tbl[6] = '{M_HAM,  8'h55, 8'h44, 1'b0, 8'h44, 64'd0, 16};

    repeat (2) @(negedge clk);
    chk_reset("rst0");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // asynchronous reset while emitting coordinate 2
    mode = M_HAM;
    tgt = 8'h44;
    bp = 1'b0;
    cand_cnt = 0;
    @(negedge clk);
    x_init = 8'h00;
    x_init_tvalid = 1'b1;
    @(posedge clk);
    #1;
    x_init_tvalid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #2;
      if (cand_cnt >= 4 && cand_tvalid) begin
        hit = 1'b1;
        break;
      end
    end
    chk("mid_emit_c2", 64'(hit), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk_reset("rst_mid");
    @(negedge clk);
    rst = 1'b0;

    v = '{M_HAM, 8'h55, 8'h00, 1'b0, 8'h00, 64'd0, 16};
    run_vec(v, 7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
